pipe_adder_n: RTL

//  Parametrised, pipelined N-bit adder with carry-in/carry-out and valid/ready flow control.

---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_slice.sv | 14 +
 rtl/pipe_adder_n.sv | 120 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared sizing helpers and defaults for the pipelined adder family.
package adder_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;

    function automatic int slice_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    function automatic bit cfg_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SL-bit slice adder: {co, s} = x + y + ci.
module adder_slice #(
    parameter int SL = 4
) (
    input  logic [SL-1:0] x,
    input  logic [SL-1:0] y,
    input  logic          ci,
    output logic [SL-1:0] s,
    output logic          co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{SL{1'b0}}, ci};

endmodule

// File: rtl/pipe_adder_n.sv
// Pipelined WIDTH-bit adder, one SL-bit slice per stage, valid/ready flow control.
// Optional signed-overflow output enabled by defining ADDER_OVF_EN.
module pipe_adder_n
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid,
`ifdef ADDER_OVF_EN
    output logic             ovf,
`endif
    input  logic             out_ready
);

    localparam int SL   = slice_w(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder_n: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
    end

    // r_acc holds finished low sum slices below the not-yet-added high slices of a.
    logic             r_vld [STAGES];
    logic             r_cy  [STAGES];
    logic [WIDTH-1:0] r_acc [STAGES];
    logic [WIDTH-1:0] r_bop [STAGES];

    logic             w_vld_in [STAGES];
    logic             w_ci     [STAGES];
    logic [WIDTH-1:0] w_acc_in [STAGES];
    logic [WIDTH-1:0] w_bop_in [STAGES];
    logic [WIDTH-1:0] w_acc_nx [STAGES];
    logic [SL-1:0]    w_s      [STAGES];
    logic             w_co     [STAGES];
    logic             w_advance;

    assign w_advance = !r_vld[LAST] || out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SL;
        localparam logic [WIDTH-1:0] MASK = (WIDTH)'({SL{1'b1}}) << LO;

        if (k == 0) begin : g_head
            assign w_vld_in[k] = in_valid;
            assign w_ci[k]     = c;
            assign w_acc_in[k] = a;
            assign w_bop_in[k] = b;
        end else begin : g_body
            assign w_vld_in[k] = r_vld[k-1];
            assign w_ci[k]     = r_cy[k-1];
            assign w_acc_in[k] = r_acc[k-1];
            assign w_bop_in[k] = r_bop[k-1];
        end

        adder_slice #(.SL(SL)) u_slice (
            .x  (w_acc_in[k][LO +: SL]),
            .y  (w_bop_in[k][LO +: SL]),
            .ci (w_ci[k]),
            .s  (w_s[k]),
            .co (w_co[k])
        );

        assign w_acc_nx[k] = (w_acc_in[k] & ~MASK) | ((WIDTH)'(w_s[k]) << LO);
    end

    // Whole pipe shifts together; a stalled output freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i] <= 1'b0;
                r_cy[i]  <= 1'b0;
                r_acc[i] <= '0;
                r_bop[i] <= '0;
            end
        end else if (w_advance) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i] <= w_vld_in[i];
                r_cy[i]  <= w_co[i];
                r_acc[i] <= w_acc_nx[i];
                r_bop[i] <= w_bop_in[i];
            end
        end
    end

    assign in_ready  = w_advance;
    assign sum       = r_acc[LAST];
    assign carry     = r_cy[LAST];
    assign out_valid = r_vld[LAST];

`ifdef ADDER_OVF_EN
    logic r_ovf;
    logic w_ovf_nx;

    // Operand MSBs are still intact when entering the last stage.
    assign w_ovf_nx = (w_acc_in[LAST][WIDTH-1] == w_bop_in[LAST][WIDTH-1]) &&
                      (w_acc_nx[LAST][WIDTH-1] != w_acc_in[LAST][WIDTH-1]);

    // Overflow flag travels with the final stage so it aligns with sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_ovf <= w_ovf_nx;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
